// File: rtl/lane_deser_align_if.sv
// Bus between the DDR capture stage and the lane deserialiser.
// Carries the serial bit pairs and alignment controls in, and the framed words and status out.
interface lane_deser_align_if #(
  parameter int unsigned LANES      = 4,
  parameter int unsigned FRAME_BITS = 8
);
  localparam int unsigned OffW = $clog2(FRAME_BITS);

  logic [LANES-1:0]            bit_rise;
  logic [LANES-1:0]            bit_fall;
  logic                        bitslip_pulse;
  logic                        align_en;
  logic [LANES*FRAME_BITS-1:0] word_data;
  logic                        word_valid;
  logic [OffW-1:0]             slip_offset;
  logic                        aligned;
  logic                        align_fail;
  logic                        lock_lost;

  modport master (
    output bit_rise, bit_fall, bitslip_pulse, align_en,
    input  word_data, word_valid, slip_offset, aligned, align_fail, lock_lost
  );

  modport slave (
    input  bit_rise, bit_fall, bitslip_pulse, align_en,
    output word_data, word_valid, slip_offset, aligned, align_fail, lock_lost
  );
endinterface

// File: rtl/lane_deser_align.sv
// Per-lane DDR-to-parallel deserialiser with full-frame bit slip.
// An auto-alignment FSM trains the shared slip offset on a known frame-lane pattern.
module lane_deser_align #(
  parameter int unsigned           LANES         = 4,
  parameter int unsigned           FRAME_BITS    = 8,
  parameter int unsigned           TRAIN_LANE    = 0,
  parameter logic [FRAME_BITS-1:0] TRAIN_PATTERN = 8'hF0,
  parameter int unsigned           SETTLE_WORDS  = 2,
  parameter int unsigned           LOCK_WORDS    = 4
) (
  input logic               i_dco_clk,
  input logic               i_rst_n,
  lane_deser_align_if.slave io_lane
);
  localparam int unsigned HistW = 2 * FRAME_BITS;
  localparam int unsigned OffW  = $clog2(FRAME_BITS);
  localparam int unsigned CntW  = $clog2(FRAME_BITS / 2);
  localparam int unsigned AttW  = $clog2(FRAME_BITS + 1);
  localparam int unsigned SetW  = $clog2(SETTLE_WORDS + 1);
  localparam int unsigned MatW  = $clog2(LOCK_WORDS + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(FRAME_BITS / 2 - 1);
  localparam logic [OffW-1:0] OffLast = OffW'(FRAME_BITS - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StSettle = 3'd1;
  localparam logic [2:0] StCheck  = 3'd2;
  localparam logic [2:0] StSlip   = 3'd3;
  localparam logic [2:0] StLocked = 3'd4;
  localparam logic [2:0] StFail   = 3'd5;

  logic [CntW-1:0]             r_cnt;
  logic                        r_word_valid;
  logic [OffW-1:0]             r_slip_offset, w_off_d, w_off_inc;
  logic [2:0]                  r_state, w_state_d;
  logic [SetW-1:0]             r_settle, w_settle_d;
  logic [MatW-1:0]             r_match, w_match_d;
  logic [AttW-1:0]             r_att, w_att_d;
  logic                        r_lock_lost, w_lost_d;
  logic                        w_capture;
  logic                        w_match;
  logic [LANES*FRAME_BITS-1:0] w_word_data;

  assign w_capture = (r_cnt == CntLast);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [HistW-1:0]      r_hist;
    logic [FRAME_BITS-1:0] r_word;
    logic [HistW-1:0]      w_hist_next;

    // Rise is the older bit, so it lands above fall.
    assign w_hist_next = {r_hist[HistW-3:0], io_lane.bit_rise[l], io_lane.bit_fall[l]};

    always_ff @(posedge i_dco_clk) begin
      if (!i_rst_n) begin
        r_hist <= '0;
        r_word <= '0;
      end else begin
        r_hist <= w_hist_next;
        if (w_capture) r_word <= w_hist_next[r_slip_offset +: FRAME_BITS];
      end
    end

    assign w_word_data[l*FRAME_BITS +: FRAME_BITS] = r_word;
  end

  assign w_match   = (w_word_data[TRAIN_LANE*FRAME_BITS +: FRAME_BITS] == TRAIN_PATTERN);
  assign w_off_inc = (r_slip_offset == OffLast) ? '0 : r_slip_offset + OffW'(1);

  always_comb begin
    w_state_d  = r_state;
    w_off_d    = r_slip_offset;
    w_settle_d = r_settle;
    w_match_d  = r_match;
    w_att_d    = r_att;
    w_lost_d   = 1'b0;
    if (!io_lane.align_en) begin
      w_state_d = StIdle;
      if (r_state == StIdle && io_lane.bitslip_pulse) w_off_d = w_off_inc;
    end else begin
      case (r_state)
        StIdle: begin
          if (io_lane.bitslip_pulse) w_off_d = w_off_inc;
          w_settle_d = '0;
          w_att_d    = '0;
          w_state_d  = StSettle;
        end
        StSettle: begin
          if (r_word_valid) begin
            w_settle_d = r_settle + SetW'(1);
            if (w_settle_d == SetW'(SETTLE_WORDS)) begin
              w_match_d = '0;
              w_state_d = StCheck;
            end
          end
        end
        StCheck: begin
          if (r_word_valid) begin
            if (w_match) begin
              w_match_d = r_match + MatW'(1);
              if (w_match_d == MatW'(LOCK_WORDS)) w_state_d = StLocked;
            end else begin
              w_state_d = StSlip;
            end
          end
        end
        StSlip: begin
          // The slip out of a lost lock starts a fresh sweep and is not counted as an attempt.
          w_off_d    = w_off_inc;
          w_settle_d = '0;
          w_att_d    = r_lock_lost ? '0 : r_att + AttW'(1);
          w_state_d  = (!r_lock_lost && w_att_d == AttW'(FRAME_BITS)) ? StFail : StSettle;
        end
        StLocked: begin
          if (r_word_valid && !w_match) begin
            w_att_d   = '0;
            w_lost_d  = 1'b1;
            w_state_d = StSlip;
          end
        end
        StFail:  w_state_d = StFail;
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_dco_clk) begin
    if (!i_rst_n) begin
      r_cnt         <= '0;
      r_word_valid  <= 1'b0;
      r_slip_offset <= '0;
      r_state       <= StIdle;
      r_settle      <= '0;
      r_match       <= '0;
      r_att         <= '0;
      r_lock_lost   <= 1'b0;
    end else begin
      r_cnt         <= w_capture ? '0 : r_cnt + CntW'(1);
      r_word_valid  <= w_capture;
      r_slip_offset <= w_off_d;
      r_state       <= w_state_d;
      r_settle      <= w_settle_d;
      r_match       <= w_match_d;
      r_att         <= w_att_d;
      r_lock_lost   <= w_lost_d;
    end
  end

  assign io_lane.word_data   = w_word_data;
  assign io_lane.word_valid  = r_word_valid;
  assign io_lane.slip_offset = r_slip_offset;
  assign io_lane.aligned     = (r_state == StLocked);
  assign io_lane.align_fail  = (r_state == StFail);
  assign io_lane.lock_lost   = r_lock_lost;
endmodule

// File: tb/tb_lane_deser_align.sv
// Self-checking bench for lane_deser_align: a bit-queue reference model checked every cycle,
// directed scenarios with literal expectations, and a randomized soak.
module tb_lane_deser_align;
  localparam int unsigned LANES  = 4;
  localparam int unsigned FB     = 8;
  localparam int unsigned TRAIN  = 0;
  localparam logic [7:0]  PAT    = 8'hF0;
  localparam int unsigned SETTLE = 2;
  localparam int unsigned LOCKW  = 4;
  localparam int M_IDLE = 0, M_SETTLE = 1, M_CHECK = 2, M_SLIP = 3, M_LOCKED = 4, M_FAIL = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lane_deser_align_if #(.LANES(LANES), .FRAME_BITS(FB)) lane_bus ();

  lane_deser_align #(
    .LANES(LANES), .FRAME_BITS(FB), .TRAIN_LANE(TRAIN), .TRAIN_PATTERN(PAT),
    .SETTLE_WORDS(SETTLE), .LOCK_WORDS(LOCKW)
  ) dut (
    .i_dco_clk(clk),
    .i_rst_n  (rst_n),
    .io_lane  (lane_bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a serial bit stream per lane plus the alignment rules.
  logic [LANES-1:0] m_bits[$];
  logic [FB-1:0]    m_word [LANES];
  bit               m_valid, m_lost, m_ready;
  int               m_cnt, m_off, m_state, m_settle, m_match, m_att;

  always @(posedge clk) begin : model
    bit            old_valid, old_lost;
    logic [FB-1:0] old_train;
    int            old_off, n;
    if (!rst_n) begin
      m_bits.delete();
      for (int i = 0; i < 2 * FB; i++) m_bits.push_back('0);
      for (int l = 0; l < LANES; l++) m_word[l] = '0;
      m_valid = 0; m_lost = 0; m_cnt = 0; m_off = 0;
      m_state = M_IDLE; m_settle = 0; m_match = 0; m_att = 0;
    end else begin
      old_valid = m_valid; old_lost = m_lost; old_train = m_word[TRAIN]; old_off = m_off;
      m_bits.push_back(lane_bus.bit_rise);
      m_bits.push_back(lane_bus.bit_fall);
      while (m_bits.size() > 2 * FB) void'(m_bits.pop_front());
      m_valid = (m_cnt == FB / 2 - 1);
      if (m_valid) begin
        n = m_bits.size();
        for (int l = 0; l < LANES; l++)
          for (int i = 0; i < FB; i++) m_word[l][i] = m_bits[n - 1 - old_off - i][l];
      end
      m_cnt  = (m_cnt + 1) % (FB / 2);
      m_lost = 0;
      if (!lane_bus.align_en) begin
        if (m_state == M_IDLE && lane_bus.bitslip_pulse) m_off = (m_off + 1) % FB;
        m_state = M_IDLE;
      end else begin
        case (m_state)
          M_IDLE: begin
            if (lane_bus.bitslip_pulse) m_off = (m_off + 1) % FB;
            m_settle = 0; m_att = 0; m_state = M_SETTLE;
          end
          M_SETTLE: if (old_valid) begin
            m_settle++;
            if (m_settle == SETTLE) begin m_state = M_CHECK; m_match = 0; end
          end
          M_CHECK: if (old_valid) begin
            if (old_train == PAT) begin
              m_match++;
              if (m_match == LOCKW) m_state = M_LOCKED;
            end else m_state = M_SLIP;
          end
          M_SLIP: begin
            m_off    = (m_off + 1) % FB;
            m_att    = old_lost ? 0 : m_att + 1;
            m_settle = 0;
            m_state  = (m_att == FB) ? M_FAIL : M_SETTLE;
          end
          M_LOCKED: if (old_valid && old_train != PAT) begin
            m_state = M_SLIP; m_att = 0; m_lost = 1;
          end
          default: ;
        endcase
      end
    end
    m_ready = 1;
  end

  always @(negedge clk) begin : compare
    logic [LANES*FB-1:0] exp_w;
    if (m_ready) begin
      for (int l = 0; l < LANES; l++) exp_w[l*FB +: FB] = m_word[l];
      chk("word_valid", lane_bus.word_valid, m_valid);
      chk("slip_offset", lane_bus.slip_offset, m_off);
      chk("aligned", lane_bus.aligned, m_state == M_LOCKED);
      chk("align_fail", lane_bus.align_fail, m_state == M_FAIL);
      chk("lock_lost", lane_bus.lock_lost, m_lost);
      chk("word_data", lane_bus.word_data, exp_w);
    end
  end

  // Stimulus: each lane repeats a word MSB-first, in phase with the DUT frame counter.
  logic [FB-1:0] pat [LANES];
  logic [FB-1:0] cur [LANES];
  int            ph;
  bit            rand_l1;

  task automatic drive();
    for (int l = 0; l < LANES; l++) begin
      lane_bus.bit_rise[l] = cur[l][FB - 1 - 2 * ph];
      lane_bus.bit_fall[l] = cur[l][FB - 2 - 2 * ph];
    end
  endtask

  task automatic tick();
    bit was_rst;
    was_rst = !rst_n;
    @(posedge clk);
    #1;
    ph = was_rst ? 0 : (ph + 1) % (FB / 2);
    if (ph == 0) begin
      for (int l = 0; l < LANES; l++) begin
        cur[l] = pat[l];
        if (l >= 2 || (rand_l1 && l == 1)) cur[l] = FB'($urandom);
      end
    end
    drive();
  endtask

  task automatic wait_valid(input string name);
    for (int k = 0; k < 12; k++) begin
      tick();
      if (lane_bus.word_valid) break;
    end
    chk({name, "_seen"}, lane_bus.word_valid, 1'b1);
  endtask

  function automatic logic flag(input int sel);
    case (sel)
      0:       return lane_bus.aligned;
      1:       return lane_bus.align_fail;
      default: return lane_bus.lock_lost;
    endcase
  endfunction

  task automatic wait_flag(input int sel, input int limit, input string name);
    for (int k = 0; k < limit; k++) begin
      tick();
      if (flag(sel)) break;
    end
    chk({name, "_seen"}, flag(sel), 1'b1);
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int           k;
    int           r;
    logic [FB-1:0] tmp;
    for (int l = 0; l < LANES; l++) begin pat[l] = '0; cur[l] = '0; end
    rand_l1 = 0; ph = 0;
    lane_bus.bitslip_pulse = 1'b0;
    lane_bus.align_en      = 1'b0;
    pat[0] = 8'hA5;
    drive();
    repeat (3) tick();
    chk("reset_word_data", lane_bus.word_data, '0);
    chk("reset_word_valid", lane_bus.word_valid, 1'b0);
    chk("reset_slip_offset", lane_bus.slip_offset, '0);

    // Passthrough at offset 0.
    rst_n = 1'b1;
    repeat (2) begin
      wait_valid("pass");
      chk("pass_word", lane_bus.word_data[7:0], 8'hA5);
      chk("pass_offset", lane_bus.slip_offset, 3'd0);
    end

    // Manual slip by one, then seven more back to zero.
    lane_bus.bitslip_pulse = 1'b1; tick(); lane_bus.bitslip_pulse = 1'b0;
    chk("slip1_offset", lane_bus.slip_offset, 3'd1);
    wait_valid("slip1");
    chk("slip1_word", lane_bus.word_data[7:0], 8'hD2);
    repeat (7) begin
      lane_bus.bitslip_pulse = 1'b1; tick(); lane_bus.bitslip_pulse = 1'b0; tick();
    end
    chk("slip8_offset", lane_bus.slip_offset, 3'd0);
    wait_valid("slip8");
    chk("slip8_word", lane_bus.word_data[7:0], 8'hA5);

    // Auto-train: 0x87 needs three slips to read as 0xF0.
    pat[0] = 8'h87; pat[1] = 8'h3C;
    lane_bus.align_en = 1'b1;
    wait_flag(0, 400, "train_aligned");
    chk("train_offset", lane_bus.slip_offset, 3'd3);
    chk("train_no_fail", lane_bus.align_fail, 1'b0);
    wait_valid("train");
    chk("train_frame_word", lane_bus.word_data[7:0], 8'hF0);
    chk("train_lane1_word", lane_bus.word_data[15:8], 8'h87);

    // Lock loss: one corrupted frame, then re-lock after a full wrap.
    for (k = 0; k < 4 && ph != FB / 2 - 1; k++) tick();
    pat[0] = 8'h00; tick(); pat[0] = 8'h87;
    wait_flag(2, 40, "lost_pulse");
    chk("lost_aligned_low", lane_bus.aligned, 1'b0);
    tick();
    chk("lost_one_cycle", lane_bus.lock_lost, 1'b0);
    wait_flag(0, 600, "relock");
    chk("relock_offset", lane_bus.slip_offset, 3'd3);

    // Fail: a constant frame lane never matches.
    lane_bus.align_en = 1'b0; tick();
    chk("idle_aligned_low", lane_bus.aligned, 1'b0);
    pat[0] = 8'h00; lane_bus.align_en = 1'b1;
    wait_flag(1, 600, "fail");
    chk("fail_offset", lane_bus.slip_offset, 3'd3);
    chk("fail_aligned_low", lane_bus.aligned, 1'b0);
    lane_bus.align_en = 1'b0; tick();
    chk("fail_clear", lane_bus.align_fail, 1'b0);

    // Randomized soak: random data, slips, enable toggles and train rotations.
    rand_l1 = 1; lane_bus.align_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      lane_bus.bitslip_pulse = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 149) == 0) lane_bus.align_en = ~lane_bus.align_en;
      if ($urandom_range(0, 99) == 0) begin
        r   = $urandom_range(0, 7);
        tmp = PAT;
        pat[0] = ($urandom_range(0, 3) == 0) ? FB'($urandom) : ((tmp << r) | (tmp >> (FB - r)));
      end
      tick();
    end
    lane_bus.bitslip_pulse = 1'b0;

    // Reset during SETTLE.
    rand_l1 = 0; pat[0] = 8'h87;
    lane_bus.align_en = 1'b0; tick();
    lane_bus.align_en = 1'b1; repeat (2) tick();
    rst_n = 1'b0; tick();
    chk("midrst_word_data", lane_bus.word_data, '0);
    chk("midrst_valid", lane_bus.word_valid, 1'b0);
    chk("midrst_offset", lane_bus.slip_offset, 3'd0);
    chk("midrst_aligned", lane_bus.aligned, 1'b0);
    chk("midrst_fail", lane_bus.align_fail, 1'b0);
    chk("midrst_lost", lane_bus.lock_lost, 1'b0);
    rst_n = 1'b1;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      tick(); k++;
      if (lane_bus.word_valid) break;
    end
    chk("first_valid_latency", k, 4);

    lane_bus.align_en = 1'b0;
    repeat (4) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/lane_deser_align.md
Name: lane_deser_align

Overview:
- Per-lane DDR-to-parallel deserialiser with a full-frame bit-slip range (0..FRAME_BITS-1 bits) and an automatic frame-alignment FSM.
- Sits directly after the DDR input capture in the ADC frontend, single dco_clk domain.
- Rise/fall bits of each lane are already retimed to posedge. Output is one FRAME_BITS word per lane per frame.
- Alignment trains on a designated frame lane carrying a known pattern. The resulting offset is applied to all lanes.

Parameters:
- LANES, 4, number of serial lanes (including the frame lane).
- FRAME_BITS, 8, bits per word; even, >= 4.
- TRAIN_LANE, 0, lane index carrying the frame pattern.
- TRAIN_PATTERN, 8'hF0, expected frame-lane word when aligned (FRAME_BITS wide).
- SETTLE_WORDS, 2, words discarded after any offset change.
- LOCK_WORDS, 4, consecutive matching words required to declare lock.

Ports:
- dco_clk  in  1  sole clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- bit_rise  in  LANES  earlier bit of the current bit pair, per lane.
- bit_fall  in  LANES  later bit of the current bit pair, per lane.
- bitslip_pulse  in  1  manual slip request, 1-cycle pulse; honoured only in IDLE.
- align_en  in  1  level; 1 runs/holds auto-alignment, 0 returns to IDLE.
- word_data  out  LANES*FRAME_BITS  lane l occupies [l*FRAME_BITS +: FRAME_BITS]; MSB = oldest bit.
- word_valid  out  1  one-cycle strobe per frame.
- slip_offset  out  $clog2(FRAME_BITS)  current bit offset.
- aligned  out  1  high while in LOCKED.
- align_fail  out  1  high while in FAIL.
- lock_lost  out  1  one-cycle pulse on the LOCKED->SLIP transition.

Behaviour:
- Reset (rst_n=0 at posedge): all outputs 0; history registers 0; frame counter 0; slip_offset 0; match/settle/attempt counters 0; FSM=IDLE.
- Serial order per cycle is rise then fall. Each posedge, each lane history (2*FRAME_BITS bits) shifts left by 2 and takes {rise,fall} into bits [1:0].
- Frame counter cnt runs 0..FRAME_BITS/2-1 and wraps.
- On the posedge where cnt==FRAME_BITS/2-1, word_data registers each lane's post-shift history window [FRAME_BITS-1+slip_offset : slip_offset], and word_valid=1 for that cycle.
- Latency: the newest bit appears in word_data at the same edge it is sampled (offset 0).
- Increasing the offset by 1 delays the window by one bit. For a repeating word w, the output is w rotated right by slip_offset.
- slip_offset wraps FRAME_BITS-1 -> 0. A change takes effect at the next capture, with no counter reset.
- FSM states and transitions:
  - IDLE: a bitslip_pulse increments slip_offset. align_en=1 -> SETTLE with settle count and attempts = 0.
  - SETTLE: count word_valid strobes; after SETTLE_WORDS strobes -> CHECK with match count = 0.
  - CHECK: on each word_valid, compare the TRAIN_LANE word to TRAIN_PATTERN.
    - Match: match count +1; on reaching LOCK_WORDS -> LOCKED.
    - Mismatch: -> SLIP.
  - SLIP: exactly one cycle. slip_offset +1 (wrapping); attempts +1. If attempts reaches FRAME_BITS -> FAIL, else -> SETTLE.
  - LOCKED: aligned=1. A mismatching train word -> SLIP with attempts cleared and lock_lost pulsed. aligned drops the same cycle lock_lost rises.
  - FAIL: align_fail=1. Holds until align_en=0.
- align_en=0 in any state -> IDLE on the next edge. aligned and align_fail clear; slip_offset is retained.
- bitslip_pulse outside IDLE is ignored. Pulse and align_en rising in the same cycle: the slip is applied and the FSM enters SETTLE.
- Word capture and word_valid run continuously in every state; data is not gated by aligned.

Test Plan:
- Passthrough: reset, align_en=0, lane0 repeating 0xA5 MSB-first in phase with the counter -> word_valid every 4 cycles, lane0 word=0xA5, slip_offset=0.
- Manual slip: same stream, one bitslip_pulse -> slip_offset=1, lane0 word=0xD2. Seven further pulses -> slip_offset=0, word=0xA5.
- Auto-train: TRAIN_LANE presents 0x87 at offset 0, lane1 presents 0x3C at offset 0, align_en=1 -> aligned=1 with slip_offset=3; frame word=0xF0, lane1 word=0x87; align_fail=0 throughout.
- Fail: frame lane constant 0x00, align_en=1 -> after 8 SLIP passes align_fail=1, aligned=0, slip_offset back to its start value. align_en=0 -> align_fail=0 next cycle.
- Lock loss: while LOCKED, corrupt one frame word to 0x00 -> lock_lost high exactly 1 cycle, aligned=0. Restoring the stream re-locks at slip_offset=3 (one full offset wrap).
- Reset mid-training: assert rst_n=0 for one edge during SETTLE -> next cycle all outputs 0, slip_offset=0, FSM IDLE; no word_valid until 4 cycles after release.
